// File: rtl/fb_pkg.sv
// Shared definitions for the framebuffer write path: command op-codes, FSM
// state encoding and default framebuffer geometry.
package fb_pkg;

    localparam int FB_WIDTH_DEF  = 160;
    localparam int FB_HEIGHT_DEF = 120;
    localparam int ADDR_W_DEF    = 15;
    localparam int COLOR_W_DEF   = 24;

    // Coordinate widths are fixed by the command interface.
    localparam int X_W = 8;
    localparam int Y_W = 7;

    localparam logic [1:0] CMD_PLOT  = 2'd0;
    localparam logic [1:0] CMD_FILL  = 2'd1;
    localparam logic [1:0] CMD_CLEAR = 2'd2;
    localparam logic [1:0] CMD_SWAP  = 2'd3;

    typedef enum logic [1:0] {
        ST_IDLE      = 2'd0,
        ST_DRAW      = 2'd1,
        ST_WAIT_DISP = 2'd2,
        ST_SWAP      = 2'd3
    } state_t;

endpackage

// File: rtl/frame_writer_rect_scanner.sv
// rect_scanner: row-major x/y walk over a normalised rectangle with the
// framebuffer address built incrementally (row_base += FB_WIDTH per row).
module rect_scanner
    import fb_pkg::*;
#(
    parameter int FB_WIDTH = FB_WIDTH_DEF,
    parameter int ADDR_W   = ADDR_W_DEF
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [X_W-1:0]    x0,
    input  logic [X_W-1:0]    x1,
    input  logic [Y_W-1:0]    y0,
    input  logic [Y_W-1:0]    y1,
    input  logic              advance,
    output logic [ADDR_W-1:0] address,
    output logic              last
);

    localparam logic [31:0]       WIDTH_BITS = 32'(FB_WIDTH);
    localparam logic [ADDR_W-1:0] ROW_STEP   = ADDR_W'(FB_WIDTH);

    logic [X_W-1:0]    x_reg;
    logic [Y_W-1:0]    y_reg;
    logic [X_W-1:0]    x0_reg;
    logic [X_W-1:0]    x1_reg;
    logic [Y_W-1:0]    y1_reg;
    logic [ADDR_W-1:0] row_base_reg;

    // Starting row base y0*FB_WIDTH as a sum of shifted copies of y0, one per
    // set bit of the constant width, so no general multiplier is needed.
    logic [ADDR_W-1:0] partial [ADDR_W];
    logic [ADDR_W-1:0] start_base;

    genvar gi;
    generate
        for (gi = 0; gi < ADDR_W; gi++) begin : g_partial
            assign partial[gi] = WIDTH_BITS[gi] ? (ADDR_W'(y0) << gi) : '0;
        end
    endgenerate

    always_comb begin
        start_base = '0;
        for (int i = 0; i < ADDR_W; i++) begin
            start_base = start_base + partial[i];
        end
    end

    assign address = row_base_reg + ADDR_W'(x_reg);
    assign last    = (x_reg == x1_reg) && (y_reg == y1_reg);

    // Holding on the last pixel keeps the address inside the frame.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            x_reg        <= '0;
            y_reg        <= '0;
            x0_reg       <= '0;
            x1_reg       <= '0;
            y1_reg       <= '0;
            row_base_reg <= '0;
        end else if (start) begin
            x_reg        <= x0;
            y_reg        <= y0;
            x0_reg       <= x0;
            x1_reg       <= x1;
            y1_reg       <= y1;
            row_base_reg <= start_base;
        end else if (advance && !last) begin
            if (x_reg == x1_reg) begin
                x_reg        <= x0_reg;
                y_reg        <= y_reg + Y_W'(1);
                row_base_reg <= row_base_reg + ROW_STEP;
            end else begin
                x_reg <= x_reg + X_W'(1);
            end
        end
    end

endmodule

// File: rtl/frame_writer.sv
// frame_writer: drawing-command front end for the double-buffered framebuffer.
// Optional write backpressure (wr_ready) with FRAME_WRITER_BACKPRESSURE_EN.
module frame_writer
    import fb_pkg::*;
#(
    parameter int FB_WIDTH  = FB_WIDTH_DEF,
    parameter int FB_HEIGHT = FB_HEIGHT_DEF,
    parameter int ADDR_W    = ADDR_W_DEF,
    parameter int COLOR_W   = COLOR_W_DEF
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               cmd_valid,
    output logic               cmd_ready,
    input  logic [1:0]         cmd_op,
    input  logic [X_W-1:0]     cmd_x0,
    input  logic [X_W-1:0]     cmd_x1,
    input  logic [Y_W-1:0]     cmd_y0,
    input  logic [Y_W-1:0]     cmd_y1,
    input  logic [COLOR_W-1:0] cmd_color,
    input  logic               disp_done,
`ifdef FRAME_WRITER_BACKPRESSURE_EN
    input  logic               wr_ready,
`endif
    output logic               wr_en,
    output logic [ADDR_W-1:0]  wr_address,
    output logic [COLOR_W-1:0] wr_data,
    output logic               write_done,
    output logic               busy
);

    localparam logic [X_W-1:0] X_MAX = X_W'(FB_WIDTH - 1);
    localparam logic [Y_W-1:0] Y_MAX = Y_W'(FB_HEIGHT - 1);

    state_t             state_reg;
    state_t             state_next;
    logic               empty_reg;
    logic               ready_reg;
    logic [COLOR_W-1:0] color_reg;

    logic               accept;
    logic               draw_start;
    logic               wr_ok;
    logic               scan_last;
    logic [X_W-1:0]     x_lo;
    logic [X_W-1:0]     x_hi;
    logic [Y_W-1:0]     y_lo;
    logic [Y_W-1:0]     y_hi;
    logic               rect_empty;

`ifdef FRAME_WRITER_BACKPRESSURE_EN
    assign wr_ok = wr_ready;
`else
    assign wr_ok = 1'b1;
`endif

    assign accept     = cmd_valid && cmd_ready;
    assign draw_start = accept && (cmd_op != CMD_SWAP);

    // Order and clip the rectangle; an origin outside the frame means no writes.
    always_comb begin
        x_lo       = cmd_x0;
        x_hi       = cmd_x1;
        y_lo       = cmd_y0;
        y_hi       = cmd_y1;
        rect_empty = 1'b0;
        case (cmd_op)
            CMD_PLOT: begin
                x_hi       = cmd_x0;
                y_hi       = cmd_y0;
                rect_empty = (cmd_x0 > X_MAX) || (cmd_y0 > Y_MAX);
            end
            CMD_CLEAR: begin
                x_lo = '0;
                x_hi = X_MAX;
                y_lo = '0;
                y_hi = Y_MAX;
            end
            default: begin
                if (cmd_x0 > cmd_x1) begin
                    x_lo = cmd_x1;
                    x_hi = cmd_x0;
                end
                if (cmd_y0 > cmd_y1) begin
                    y_lo = cmd_y1;
                    y_hi = cmd_y0;
                end
                if (x_hi > X_MAX) x_hi = X_MAX;
                if (y_hi > Y_MAX) y_hi = Y_MAX;
                rect_empty = (x_lo > X_MAX) || (y_lo > Y_MAX);
            end
        endcase
    end

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            ST_IDLE: begin
                if (accept) begin
                    state_next = (cmd_op == CMD_SWAP) ? ST_WAIT_DISP : ST_DRAW;
                end
            end
            ST_DRAW: begin
                if (empty_reg || (scan_last && wr_ok)) state_next = ST_IDLE;
            end
            ST_WAIT_DISP: begin
                if (disp_done) state_next = ST_SWAP;
            end
            ST_SWAP: begin
                if (wr_ok) state_next = ST_IDLE;
            end
            default: state_next = ST_IDLE;
        endcase
    end

    assign wr_en      = (state_reg == ST_DRAW) && !empty_reg;
    assign write_done = (state_reg == ST_SWAP);
    assign busy       = (state_reg != ST_IDLE);
    assign wr_data    = color_reg;
    // Registered so that cmd_ready stays low while reset is held.
    assign cmd_ready  = ready_reg;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_reg <= ST_IDLE;
            empty_reg <= 1'b0;
            ready_reg <= 1'b0;
            color_reg <= '0;
        end else begin
            state_reg <= state_next;
            ready_reg <= (state_next == ST_IDLE);
            if (draw_start) begin
                empty_reg <= rect_empty;
                color_reg <= cmd_color;
            end
        end
    end

    rect_scanner #(
        .FB_WIDTH (FB_WIDTH),
        .ADDR_W   (ADDR_W)
    ) u_scanner (
        .clk     (clk),
        .rst     (rst),
        .start   (draw_start),
        .x0      (x_lo),
        .x1      (x_hi),
        .y0      (y_lo),
        .y1      (y_hi),
        .advance (wr_en && wr_ok),
        .address (wr_address),
        .last    (scan_last)
    );

endmodule

// File: tb/tb_frame_writer.sv
// Directed, table-driven bench for frame_writer: drawing vectors, swap timing
// against disp_done, asynchronous reset mid-clear and optional backpressure.
module tb_frame_writer;
    import fb_pkg::*;

    logic        clk;
    logic        rst;
    logic        cmd_valid;
    logic        cmd_ready;
    logic [1:0]  cmd_op;
    logic [7:0]  cmd_x0;
    logic [7:0]  cmd_x1;
    logic [6:0]  cmd_y0;
    logic [6:0]  cmd_y1;
    logic [23:0] cmd_color;
    logic        disp_done;
    logic        wr_en;
    logic [14:0] wr_address;
    logic [23:0] wr_data;
    logic        write_done;
    logic        busy;
`ifdef FRAME_WRITER_BACKPRESSURE_EN
    logic        wr_ready;
`endif

    int errors = 0;
    int checks = 0;

    frame_writer dut (
        .clk        (clk),
        .rst        (rst),
        .cmd_valid  (cmd_valid),
        .cmd_ready  (cmd_ready),
        .cmd_op     (cmd_op),
        .cmd_x0     (cmd_x0),
        .cmd_x1     (cmd_x1),
        .cmd_y0     (cmd_y0),
        .cmd_y1     (cmd_y1),
        .cmd_color  (cmd_color),
        .disp_done  (disp_done),
`ifdef FRAME_WRITER_BACKPRESSURE_EN
        .wr_ready   (wr_ready),
`endif
        .wr_en      (wr_en),
        .wr_address (wr_address),
        .wr_data    (wr_data),
        .write_done (write_done),
        .busy       (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [1:0]  op;
        logic [7:0]  x0;
        logic [7:0]  x1;
        logic [6:0]  y0;
        logic [6:0]  y1;
        logic [23:0] color;
        bit          empty;
        int          ex_lo;
        int          ex_hi;
        int          ey_lo;
        int          ey_hi;
    } vec_t;

    vec_t vecs [12];

    task automatic check(input string name, input longint act, input longint exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Present a command, wait (bounded) for acceptance, then scramble inputs.
    task automatic issue(input logic [1:0] op, input logic [7:0] x0, input logic [7:0] x1,
                         input logic [6:0] y0, input logic [6:0] y1, input logic [23:0] color,
                         input string name);
        int n;
        cmd_op    = op;
        cmd_x0    = x0;
        cmd_x1    = x1;
        cmd_y0    = y0;
        cmd_y1    = y1;
        cmd_color = color;
        cmd_valid = 1'b1;
        n = 0;
        while (!cmd_ready && n < 20) begin
            step();
            n++;
        end
        check({name, " ready_before_accept"}, cmd_ready, 1);
        step();
        cmd_valid = 1'b0;
        cmd_x0    = 8'hAA;
        cmd_x1    = 8'h11;
        cmd_y0    = 7'h55;
        cmd_y1    = 7'h22;
        cmd_color = ~color;
        cmd_op    = CMD_FILL;
    endtask

    task automatic run_vec(input vec_t v, input int idx);
        string nm;
        int    n_en;
        int    bad_addr;
        int    bad_data;
        int    exp_cnt;
        nm = $sformatf("vec%0d", idx);
        issue(v.op, v.x0, v.x1, v.y0, v.y1, v.color, nm);
        if (v.empty) begin
            check({nm, " empty_wr_en"}, wr_en, 0);
            check({nm, " empty_busy"}, busy, 1);
            step();
        end else begin
            n_en     = 0;
            bad_addr = 0;
            bad_data = 0;
            exp_cnt  = (v.ex_hi - v.ex_lo + 1) * (v.ey_hi - v.ey_lo + 1);
            check({nm, " busy_first"}, busy, 1);
            for (int y = v.ey_lo; y <= v.ey_hi; y++) begin
                for (int x = v.ex_lo; x <= v.ex_hi; x++) begin
                    if (wr_en) n_en++;
                    if (int'(wr_address) != y * 160 + x) begin
                        if (bad_addr == 0)
                            $display("  %s first address error at (%0d,%0d): got %0d", nm, x, y, wr_address);
                        bad_addr++;
                    end
                    if (wr_data !== v.color) bad_data++;
                    step();
                end
            end
            check({nm, " wr_en_cycles"}, n_en, exp_cnt);
            check({nm, " addr_errors"}, bad_addr, 0);
            check({nm, " data_errors"}, bad_data, 0);
            check({nm, " wr_en_after"}, wr_en, 0);
        end
        check({nm, " ready_after"}, cmd_ready, 1);
        check({nm, " busy_after"}, busy, 0);
        $display("vec%0d op=%0d (%0d,%0d)-(%0d,%0d) color=%06h done", idx, v.op, v.x0, v.y0, v.x1, v.y1, v.color);
    endtask

    initial begin
        int n;
        vecs[0]  = '{CMD_PLOT,  8'd3,   8'd99,  7'd2,   7'd50,  24'hFF0000, 0, 3,   3,   2,   2};
        vecs[1]  = '{CMD_PLOT,  8'd159, 8'd0,   7'd119, 7'd0,   24'h0000AA, 0, 159, 159, 119, 119};
        vecs[2]  = '{CMD_PLOT,  8'd160, 8'd0,   7'd0,   7'd0,   24'h111111, 1, 0,   0,   0,   0};
        vecs[3]  = '{CMD_PLOT,  8'd0,   8'd0,   7'd120, 7'd0,   24'h222222, 1, 0,   0,   0,   0};
        vecs[4]  = '{CMD_FILL,  8'd0,   8'd1,   7'd0,   7'd1,   24'h00FF00, 0, 0,   1,   0,   1};
        vecs[5]  = '{CMD_FILL,  8'd5,   8'd2,   7'd119, 7'd119, 24'h0000FF, 0, 2,   5,   119, 119};
        vecs[6]  = '{CMD_FILL,  8'd150, 8'd200, 7'd0,   7'd0,   24'h808080, 0, 150, 159, 0,   0};
        vecs[7]  = '{CMD_FILL,  8'd12,  8'd10,  7'd7,   7'd5,   24'hC0FFEE, 0, 10,  12,  5,   7};
        vecs[8]  = '{CMD_FILL,  8'd170, 8'd200, 7'd0,   7'd3,   24'h333333, 1, 0,   0,   0,   0};
        vecs[9]  = '{CMD_FILL,  8'd0,   8'd5,   7'd125, 7'd127, 24'h444444, 1, 0,   0,   0,   0};
        vecs[10] = '{CMD_FILL,  8'd200, 8'd3,   7'd1,   7'd1,   24'hABCDEF, 0, 3,   159, 1,   1};
        vecs[11] = '{CMD_CLEAR, 8'd77,  8'd9,   7'd33,  7'd4,   24'h123456, 0, 0,   159, 0,   119};

        rst       = 1'b0;
        cmd_valid = 1'b0;
        cmd_op    = CMD_PLOT;
        cmd_x0    = '0;
        cmd_x1    = '0;
        cmd_y0    = '0;
        cmd_y1    = '0;
        cmd_color = '0;
        disp_done = 1'b0;
`ifdef FRAME_WRITER_BACKPRESSURE_EN
        wr_ready  = 1'b1;
`endif

        // Reset state
        step();
        step();
        check("rst wr_en", wr_en, 0);
        check("rst busy", busy, 0);
        check("rst cmd_ready", cmd_ready, 0);
        check("rst write_done", write_done, 0);
        check("rst wr_address", wr_address, 0);
        check("rst wr_data", wr_data, 0);
        rst = 1'b1;
        step();
        check("post_rst cmd_ready", cmd_ready, 1);
        $display("reset sequence done");

        for (int i = 0; i < 12; i++) run_vec(vecs[i], i);

        // SWAP: disp_done coincident with acceptance is ignored
        cmd_op    = CMD_SWAP;
        cmd_valid = 1'b1;
        disp_done = 1'b1;
        check("swap ready", cmd_ready, 1);
        step();
        cmd_valid = 1'b0;
        disp_done = 1'b0;
        check("swap wait busy", busy, 1);
        check("swap wait cmd_ready", cmd_ready, 0);
        n = 0;
        for (int c = 0; c < 49; c++) begin
            if (write_done) n++;
            step();
        end
        check("swap early write_done cycles", n, 0);
        disp_done = 1'b1;
        check("swap write_done before pulse", write_done, 0);
        step();
        disp_done = 1'b0;
        check("swap write_done", write_done, 1);
        step();
        check("swap write_done pulse width", write_done, 0);
        check("swap ready_after", cmd_ready, 1);
        check("swap busy_after", busy, 0);
        $display("swap sequence done");

        // Reset asserted during CLEAR at pixel 1000
        issue(CMD_CLEAR, 8'd0, 8'd0, 7'd0, 7'd0, 24'h00FFFF, "clr_rst");
        for (int p = 0; p < 1000; p++) step();
        check("clr_rst wr_en at 1000", wr_en, 1);
        check("clr_rst addr at 1000", wr_address, 1000);
        #2;
        rst = 1'b0;
        #1;
        check("clr_rst async wr_en", wr_en, 0);
        check("clr_rst async busy", busy, 0);
        check("clr_rst async cmd_ready", cmd_ready, 0);
        step();
        step();
        rst = 1'b1;
        step();
        check("clr_rst ready after release", cmd_ready, 1);
        n = 0;
        for (int c = 0; c < 30; c++) begin
            if (wr_en) n++;
            step();
        end
        check("clr_rst stray writes", n, 0);
        $display("reset during clear done");

`ifdef FRAME_WRITER_BACKPRESSURE_EN
        // wr_ready low for 3 cycles on pixel 1 of a 4-pixel row
        begin
            int bad;
            int expa;
            issue(CMD_FILL, 8'd0, 8'd3, 7'd0, 7'd0, 24'hABCDEF, "bp");
            n   = 0;
            bad = 0;
            for (int c = 0; c < 20 && wr_en; c++) begin
                n++;
                if (n == 2) wr_ready = 1'b0;
                if (n == 5) wr_ready = 1'b1;
                expa = (n <= 1) ? 0 : (n <= 5) ? 1 : n - 4;
                if (int'(wr_address) != expa || wr_data !== 24'hABCDEF) bad++;
                step();
            end
            wr_ready = 1'b1;
            check("bp wr_en cycles", n, 7);
            check("bp held errors", bad, 0);
            check("bp ready_after", cmd_ready, 1);
            $display("backpressure sequence done");
        end
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/frame_writer.md
Name: frame_writer

Overview:
- Write-side producer for the pixel framebuffer's double buffer; the display controller consumes the other side.
- Accepts drawing commands from the processor (plot pixel, fill rectangle, clear, swap) over a valid/ready handshake.
- Emits one pixel write per cycle: address, 24-bit colour and write enable.
- Pulses write_done, synchronised to the display's disp_done, so the buffers swap only between frames.

Parameters:
- FB_WIDTH, 160, pixels per row.
- FB_HEIGHT, 120, rows per frame.
- ADDR_W, 15, framebuffer address width; must satisfy 2^ADDR_W >= FB_WIDTH*FB_HEIGHT.
- COLOR_W, 24, pixel width, {r[7:0], g[7:0], b[7:0]}.

Ports:
- clk  in  1  system clock, the same clock as the double buffer.
- rst  in  1  asynchronous, active-low reset.
- cmd_valid  in  1  command present.
- cmd_ready  out  1  command accepted when cmd_valid && cmd_ready.
- cmd_op  in  2  0=PLOT, 1=FILL, 2=CLEAR, 3=SWAP.
- cmd_x0, cmd_x1  in  8  column coordinates.
- cmd_y0, cmd_y1  in  7  row coordinates.
- cmd_color  in  COLOR_W  fill colour.
- disp_done  in  1  one-cycle pulse from the display driver at end of frame.
- wr_en  out  1  pixel write strobe.
- wr_address  out  ADDR_W  row-major address = y*FB_WIDTH + x.
- wr_data  out  COLOR_W  pixel colour.
- write_done  out  1  one-cycle buffer-swap request.
- busy  out  1  high in any state other than IDLE.

Behaviour:
- Reset (rst=0, asynchronous):
  - State goes to IDLE.
  - wr_en=0, wr_address=0, wr_data=0, write_done=0, busy=0, cmd_ready=0 while asserted.
  - Reset mid-command aborts it; no further writes occur.
- cmd_ready=1 only in IDLE. Command fields are registered at acceptance; later input changes are ignored.
- State machine:
  - IDLE -> DRAW on PLOT, FILL or CLEAR.
  - IDLE -> WAIT_DISP on SWAP.
  - DRAW -> IDLE after the last pixel.
  - WAIT_DISP -> SWAP on disp_done.
  - SWAP -> IDLE after one cycle; write_done=1 in SWAP only.
- Normalisation at acceptance:
  - If x0>x1, swap them; if y0>y1, swap them.
  - Clip x1 to FB_WIDTH-1 and y1 to FB_HEIGHT-1.
  - FILL with x0>=FB_WIDTH or y0>=FB_HEIGHT after ordering produces zero writes and returns to IDLE on the next cycle.
  - PLOT uses (x0,y0) only; an out-of-range coordinate produces no write.
  - CLEAR is FILL over (0,0)-(FB_WIDTH-1,FB_HEIGHT-1).
- Scan order and timing:
  - Row-major: x increments from x0 to x1, then y increments and x reloads x0.
  - One pixel per cycle; the first wr_en appears the cycle after acceptance.
  - A W×H rectangle gives exactly W*H consecutive wr_en cycles, then IDLE with cmd_ready=1 on the next cycle.
- Address arithmetic:
  - Computed incrementally with no multiplier: row_base += FB_WIDTH per row, wr_address = row_base + x.
  - The address never exceeds FB_WIDTH*FB_HEIGHT-1 (19199 at defaults).
- wr_data holds cmd_color for the whole command.
- disp_done is sampled only in WAIT_DISP. A pulse coincident with SWAP acceptance is ignored, so the swap waits for the next frame end.
- write_done rises the cycle after disp_done is sampled.

Optional Feature:
- Macro: FRAME_WRITER_BACKPRESSURE_EN.
- Defined:
  - Adds input wr_ready (1 bit).
  - A write completes only when wr_en && wr_ready.
  - wr_en, wr_address and wr_data hold stable while wr_ready=0, and the scan does not advance.
  - The SWAP state holds write_done until wr_ready=1.
- Undefined: no wr_ready port; every write completes in one cycle.

Decomposition:
- Package fb_pkg holds:
  - op-code constants CMD_PLOT, CMD_FILL, CMD_CLEAR, CMD_SWAP;
  - state encoding;
  - FB_WIDTH/FB_HEIGHT defaults.
- One sub-module, rect_scanner:
  - x/y counters and incremental row_base address generation;
  - inputs: start, bounds, advance;
  - outputs: address, last.
- The FSM, normalisation and handshake stay in frame_writer.

Test Plan:
- PLOT (3,2), colour 0xFF0000 -> single wr_en cycle one cycle after acceptance, address 323, data 0xFF0000; busy for 1 cycle.
- FILL (0,0)-(1,1), colour 0x00FF00 -> wr_en on 4 consecutive cycles, addresses 0,1,160,161; cmd_ready=1 on the cycle after.
- FILL x0=5,x1=2,y0=y1=119,x1... i.e. corners (5,119)-(2,119) -> addresses 19042..19045 in order; FILL (150,0)-(200,0) -> clipped, addresses 150..159.
- CLEAR -> 19200 writes, last address 19199, no wr_en afterwards.
- SWAP with disp_done pulsed in the same cycle, then again 50 cycles later -> single write_done exactly one cycle after the second pulse.
- Reset asserted during CLEAR at pixel 1000 -> wr_en=0 immediately (asynchronous); after release cmd_ready=1 and no stray writes. With FRAME_WRITER_BACKPRESSURE_EN, wr_ready low for 3 cycles on pixel 1 -> address/data held, total cycle count +3.
